// File: rtl/cpu_pkg.sv
// Shared CPU constants: operand timing codes, MD op encodings
// and multiply/divide latencies used by the hazard logic.
package cpu_pkg;

   localparam int TUSE_W = 2;

   // Tuse value meaning "this operand is not read".
   localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] MD_NONE = 2'd0;
   localparam logic [1:0] MD_MULT = 2'd1;
   localparam logic [1:0] MD_DIV  = 2'd2;
   localparam logic [1:0] MD_RSVD = 2'd3;

   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks occupancy of the multiply/divide unit.
// Ports: i_clk, i_rst_n (async low), i_md_op (E-stage op), o_busy.
module md_busy_tracker
   import cpu_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_md_op,
   output logic       o_busy
);

   localparam logic S_IDLE = 1'b0;
   localparam logic S_BUSY = 1'b1;

   logic       r_state;
   logic [3:0] r_md_cnt;
   logic       w_start_mult;
   logic       w_start_div;

   assign w_start_mult = (i_md_op == MD_MULT);
   assign w_start_div  = (i_md_op == MD_DIV);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_md_cnt <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               // Start cycle is already busy, so load latency-1.
               if (w_start_mult) begin
                  r_state  <= S_BUSY;
                  r_md_cnt <= 4'(MULT_CYCLES - 1);
               end else if (w_start_div) begin
                  r_state  <= S_BUSY;
                  r_md_cnt <= 4'(DIV_CYCLES - 1);
               end
            end
            S_BUSY: begin
               // New starts are ignored here; no reload.
               r_md_cnt <= r_md_cnt - 4'd1;
               if (r_md_cnt <= 4'd1) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_md_cnt <= '0;
            end
         endcase
      end
   end

   // Reset gating keeps busy low while reset is held.
   assign o_busy = i_rst_n &
                   ((r_state == S_BUSY) | w_start_mult | w_start_div);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew stall detection plus MD busy stall.
// Ports: clk, reset (async low), D/E/M register+timing fields, D_is_md,
// E_md_op; outputs PC_WE, FD_WE, DE_flush, md_busy, and stall_cnt when
// HAZARD_STAT_EN is defined.
module hazard_ctrl
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        D_rs,
   input  logic [4:0]        D_rt,
   input  logic [TUSE_W-1:0] D_rs_Tuse,
   input  logic [TUSE_W-1:0] D_rt_Tuse,
   input  logic [4:0]        E_A3,
   input  logic [4:0]        M_A3,
   input  logic [TUSE_W-1:0] E_Tnew,
   input  logic [TUSE_W-1:0] M_Tnew,
   input  logic              D_is_md,
   input  logic [1:0]        E_md_op,
   output logic              PC_WE,
   output logic              FD_WE,
   output logic              DE_flush,
   output logic              md_busy
`ifdef HAZARD_STAT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   logic w_stall_rs;
   logic w_stall_rt;
   logic w_stall_md;
   logic w_stall;
   logic w_md_busy;

   // Register 0 never creates a dependency; Tuse 3 means unread.
   assign w_stall_rs = (D_rs != 5'd0) && (D_rs_Tuse != TUSE_NONE) &&
                       (((E_A3 == D_rs) && (E_Tnew > D_rs_Tuse)) ||
                        ((M_A3 == D_rs) && (M_Tnew > D_rs_Tuse)));

   assign w_stall_rt = (D_rt != 5'd0) && (D_rt_Tuse != TUSE_NONE) &&
                       (((E_A3 == D_rt) && (E_Tnew > D_rt_Tuse)) ||
                        ((M_A3 == D_rt) && (M_Tnew > D_rt_Tuse)));

   md_busy_tracker u_md (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_md_op (E_md_op),
      .o_busy  (w_md_busy)
   );

   assign w_stall_md = D_is_md & w_md_busy;
   assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

   // During reset the pipeline is frozen and D/E holds a bubble.
   assign PC_WE    = reset & ~w_stall;
   assign FD_WE    = reset & ~w_stall;
   assign DE_flush = ~reset | w_stall;
   assign md_busy  = w_md_busy;

`ifdef HAZARD_STAT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Stall-counter checks are built only with HAZARD_STAT_EN.
module tb_hazard_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  D_rs;
   logic [4:0]  D_rt;
   logic [1:0]  D_rs_Tuse;
   logic [1:0]  D_rt_Tuse;
   logic [4:0]  E_A3;
   logic [4:0]  M_A3;
   logic [1:0]  E_Tnew;
   logic [1:0]  M_Tnew;
   logic        D_is_md;
   logic [1:0]  E_md_op;
   logic        PC_WE;
   logic        FD_WE;
   logic        DE_flush;
   logic        md_busy;
`ifdef HAZARD_STAT_EN
   logic [31:0] stall_cnt;
`endif

   int n_total = 0;
   int n_bad   = 0;

   hazard_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .D_rs      (D_rs),
      .D_rt      (D_rt),
      .D_rs_Tuse (D_rs_Tuse),
      .D_rt_Tuse (D_rt_Tuse),
      .E_A3      (E_A3),
      .M_A3      (M_A3),
      .E_Tnew    (E_Tnew),
      .M_Tnew    (M_Tnew),
      .D_is_md   (D_is_md),
      .E_md_op   (E_md_op),
      .PC_WE     (PC_WE),
      .FD_WE     (FD_WE),
      .DE_flush  (DE_flush),
      .md_busy   (md_busy)
`ifdef HAZARD_STAT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr_haz();
      D_rs = 0; D_rt = 0;
      D_rs_Tuse = 2'd3; D_rt_Tuse = 2'd3;
      E_A3 = 0; M_A3 = 0;
      E_Tnew = 0; M_Tnew = 0;
   endtask

   task automatic chk_out(input string tag, input logic stall);
      #1;
      chk({tag, "_pc"}, 32'(PC_WE), 32'(!stall));
      chk({tag, "_fd"}, 32'(FD_WE), 32'(!stall));
      chk({tag, "_fl"}, 32'(DE_flush), 32'(stall));
   endtask

   initial begin
      reset = 1'b0;
      clr_haz();
      D_is_md = 1'b0;
      E_md_op = 2'd1;
      #3;
      chk("rst_pc", 32'(PC_WE), 32'd0);
      chk("rst_fd", 32'(FD_WE), 32'd0);
      chk("rst_fl", 32'(DE_flush), 32'd1);
      chk("rst_busy", 32'(md_busy), 32'd0);
      E_md_op = 2'd0;
      @(posedge clk); #1;
      reset = 1'b1;
      chk_out("idle", 1'b0);
      chk("idle_busy", 32'(md_busy), 32'd0);
`ifdef HAZARD_STAT_EN
      chk("cnt_rst", stall_cnt, 32'd0);
`endif

      // E-stage rs hazard
      D_rs = 5; D_rs_Tuse = 0; E_A3 = 5; E_Tnew = 1;
      chk_out("e_rs", 1'b1);
      D_rs_Tuse = 1;
      chk_out("e_rs_eq", 1'b0);
      E_Tnew = 2;
      chk_out("e_rs_gt", 1'b1);
      D_rs_Tuse = 2; E_Tnew = 3;
      chk_out("e_rs_uns", 1'b1);
      E_Tnew = 0; D_rs_Tuse = 0;
      chk_out("e_rs_t0", 1'b0);
      clr_haz();

      // M-stage rt hazard
      D_rt = 7; D_rt_Tuse = 0; M_A3 = 7; M_Tnew = 1;
      chk_out("m_rt", 1'b1);
      D_rt_Tuse = 3; M_Tnew = 3;
      chk_out("m_rt_unused", 1'b0);
      clr_haz();

      // register 0 never stalls
      D_rt = 0; D_rt_Tuse = 0; E_A3 = 0; E_Tnew = 2;
      chk_out("r0", 1'b0);
      clr_haz();

      // div: 10 busy cycles, D holds an md instruction
      @(posedge clk); #1;
      E_md_op = 2'd2; D_is_md = 1'b1;
      for (int k = 0; k < 12; k++) begin
         #1;
         chk($sformatf("div_busy%0d", k), 32'(md_busy), 32'(k < 10));
         chk($sformatf("div_fl%0d", k), 32'(DE_flush), 32'(k < 10));
         @(posedge clk); #1;
         E_md_op = 2'd0;
      end
      D_is_md = 1'b0;

      // mult with a div arriving mid-operation: no reload
      E_md_op = 2'd1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("mul_busy%0d", k), 32'(md_busy), 32'(k < 5));
         @(posedge clk); #1;
         E_md_op = (k == 1) ? 2'd2 : 2'd0;
      end

      // combined reg + md hazard gives one ordinary stall
      E_md_op = 2'd1; D_is_md = 1'b1;
      D_rs = 5; D_rs_Tuse = 0; E_A3 = 5; E_Tnew = 1;
      chk_out("both", 1'b1);
      clr_haz();
      D_is_md = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         E_md_op = 2'd0;
      end

      // reset during third div cycle
      E_md_op = 2'd2;
      @(posedge clk); #1;
      E_md_op = 2'd0;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("rd_busy", 32'(md_busy), 32'd0);
      chk("rd_fl", 32'(DE_flush), 32'd1);
      chk("rd_pc", 32'(PC_WE), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      D_is_md = 1'b1;
      #1;
      chk("rr_busy", 32'(md_busy), 32'd0);
      chk("rr_pc", 32'(PC_WE), 32'd1);
      @(posedge clk); #1;
      chk("rr_busy2", 32'(md_busy), 32'd0);
      D_is_md = 1'b0;

`ifdef HAZARD_STAT_EN
      chk("cnt_clr", stall_cnt, 32'd0);
      D_rs = 5; D_rs_Tuse = 0; E_A3 = 5; E_Tnew = 1;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
      end
      clr_haz();
      @(posedge clk); #1;
      chk("cnt7", stall_cnt, 32'd7);
      dut.r_stall_cnt = 32'hFFFF_FFFF;
      D_rs = 5; D_rs_Tuse = 0; E_A3 = 5; E_Tnew = 1;
      @(posedge clk); #1;
      clr_haz();
      chk("cnt_wrap", stall_cnt, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; both are listed first below.
REQ-002 SHALL provide `clk`, input, 1 bit: the single rising-edge clock.
REQ-003 SHALL provide `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide `D_rs` and `D_rt`, inputs, 5 bits each: source register numbers of the instruction in D.
REQ-005 SHALL provide `D_rs_Tuse` and `D_rt_Tuse`, inputs, 2 bits each: cycles until the operand is needed; 3 = operand not used.
REQ-006 SHALL provide `E_A3` and `M_A3`, inputs, 5 bits each: destination registers in E and M.
REQ-007 SHALL provide `E_Tnew` and `M_Tnew`, inputs, 2 bits each: cycles until the result is available.
REQ-008 SHALL provide `D_is_md`, input, 1 bit: the instruction in D accesses HI/LO (mult, div, mfhi, mflo, mthi, mtlo).
REQ-009 SHALL provide `E_md_op`, input, 2 bits: 0 = none, 1 = mult/multu, 2 = div/divu, 3 = reserved (treated as none).
REQ-010 SHALL provide `PC_WE`, output, 1 bit: write enable for the PC register.
REQ-011 SHALL provide `FD_WE`, output, 1 bit: write enable for the F/D pipeline register.
REQ-012 SHALL provide `DE_flush`, output, 1 bit: inserts a nop into the D/E register.
REQ-013 SHALL provide `md_busy`, output, 1 bit: the multiply/divide unit is occupied.
REQ-014 SHALL provide `stall_cnt`, output, 32 bits, present only when `HAZARD_STAT_EN` is defined.

Function
REQ-015 SHALL assert `stall_rs` when all of: `D_rs` != 0; and either (`E_A3` == `D_rs` and `E_Tnew` > `D_rs_Tuse`) or (`M_A3` == `D_rs` and `M_Tnew` > `D_rs_Tuse`).
REQ-016 SHALL compute `stall_rt` identically, using `D_rt` and `D_rt_Tuse`.
REQ-017 SHALL compare the Tnew and Tuse fields as unsigned 2-bit values.
REQ-018 SHALL assert `stall_md` when `D_is_md` is 1 and `md_busy` is 1.
REQ-019 SHALL define stall = `stall_rs` | `stall_rt` | `stall_md`.
REQ-020 SHALL drive, combinationally in the same cycle: `PC_WE` = !stall, `FD_WE` = !stall, `DE_flush` = stall.
REQ-021 SHALL implement a busy tracker FSM with two states, IDLE and BUSY, and a 4-bit down-counter `md_cnt`.
REQ-022 SHALL, in IDLE with `E_md_op` = 1, go to BUSY at the next edge with `md_cnt` = 4, giving 5 busy cycles including the start cycle.
REQ-023 SHALL, in IDLE with `E_md_op` = 2, go to BUSY with `md_cnt` = 9, giving 10 busy cycles.
REQ-024 SHALL, in BUSY, decrement `md_cnt` each cycle and return to IDLE on the edge where `md_cnt` = 1 is decremented.
REQ-025 SHALL drive `md_busy` = (state == BUSY) | (`E_md_op` ∈ {1, 2}), so the start cycle already counts as busy.
REQ-026 SHALL ignore an `E_md_op` start that arrives while in BUSY; the counter is not reloaded.
REQ-027 SHALL NOT flush or stall on a hazard whose source register is 0, even if `E_A3` or `M_A3` is 0.
REQ-028 SHALL treat a simultaneous register hazard and md hazard as a single stall with identical outputs.

Reset
REQ-029 SHALL, while `reset` = 0, force state = IDLE, `md_cnt` = 0 and `stall_cnt` = 0, asynchronously.
REQ-030 SHALL, while `reset` = 0, drive `PC_WE` = 0, `FD_WE` = 0, `DE_flush` = 1 and `md_busy` = 0.
REQ-031 SHALL let reset during BUSY abort the operation; after release the block is in IDLE with `md_busy` = 0.

Configuration
REQ-032 SHALL, with `HAZARD_STAT_EN` defined, increment `stall_cnt` by 1 on every clock edge in which stall = 1, wrapping from 0xFFFF_FFFF to 0.
REQ-033 SHALL, without `HAZARD_STAT_EN`, omit both the port and the counter, with no other behavioural change.

Structure
REQ-034 SHALL place the following in the shared package `cpu_pkg`: the Tuse/Tnew width and the "unused" code 3, the MD_OP encodings, and the constants `MULT_CYCLES` = 5 and `DIV_CYCLES` = 10.
REQ-035 SHALL implement the FSM and counter as the sub-module `md_busy_tracker`; hazard comparison stays in the top level.

Verification
REQ-036 SHALL cover: `D_rs` = 5, `D_rs_Tuse` = 0, `E_A3` = 5, `E_Tnew` = 1 -> `DE_flush` = 1, `PC_WE` = 0, `FD_WE` = 0 in that cycle.
REQ-037 SHALL cover: `D_rt` = 0, `D_rt_Tuse` = 0, `E_A3` = 0, `E_Tnew` = 2 -> no stall, `PC_WE` = 1.
REQ-038 SHALL cover: `E_md_op` = 2 for one cycle, then `D_is_md` = 1 held -> `md_busy` = 1 for exactly 10 cycles and `DE_flush` = 1 for those 10 cycles, then 0.
REQ-039 SHALL cover: `E_md_op` = 1, then `E_md_op` = 2 in the third busy cycle -> busy ends after 5 cycles total, no reload.
REQ-040 SHALL cover: reset pulled low in the 3rd cycle of a div -> `md_busy` = 0 immediately; after release, IDLE and `md_busy` = 0.
REQ-041 SHALL cover, with `HAZARD_STAT_EN` defined: 7 stall cycles injected -> `stall_cnt` = 7; with `stall_cnt` preloaded to 0xFFFF_FFFF and one stall -> 0.
